data_transfer_seq: RTL and testbench

//  Sequences lw (opcode 8) / sw (opcode 9) against a handshaked data memory.

---
 rtl/data_transfer_seq.sv | 182 ++++++++++++++++++
 tb/tb_data_transfer_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_transfer_seq.sv
// data_transfer_seq: lw/sw load-store sequencer between execute and data memory.
// Latches a request, forms rs+rt, checks alignment and opcode, runs the mem handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 request strobe, taken only while idle
//   opcode                8 = lw, 9 = sw, others illegal
//   rs, rt, wdata         base address, signed offset, store data
//   busy                  transaction in flight (after accept, through done)
//   done, err, err_code   one-cycle completion pulse and error qualifier
//   rdata                 data of the last successful load
//   mem_req, mem_we       memory request and write enable
//   mem_addr, mem_wdata   word-aligned byte address and store data
//   mem_ack, mem_rdata    memory completion and load data
module data_transfer_seq #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [5:0]        op;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [5:0] OP_LW = 6'd8;
  localparam logic [5:0] OP_SW = 6'd9;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ALIGN = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;
  localparam logic [1:0] E_OPC   = 2'b11;

  // cnt holds the number of unacked REQ cycles already spent; the
  // edge that would bring it to TIMEOUT ends the request instead.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t            state;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] addr;
  logic              is_lw;
  logic              is_sw;
  logic              legal;
  logic              misal;

  // Address wraps modulo 2^DATA_W; no overflow is reported.
  assign addr  = req_q.rs + req_q.rt;
  assign misal = |addr[1:0];

  always_comb begin
    is_lw = 1'b0;
    is_sw = 1'b0;
    unique case (1'b1)
      (req_q.op == OP_LW): is_lw = 1'b1;
      (req_q.op == OP_SW): is_sw = 1'b1;
      default: ;
    endcase
  end

  assign legal = is_lw | is_sw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            req_q.op    <= opcode;
            req_q.rs    <= rs;
            req_q.rt    <= rt;
            req_q.wdata <= wdata;
            err_code    <= E_NONE;
            busy        <= 1'b1;
            state       <= S_CALC;
          end
        end
        S_CALC: begin
          // Illegal opcode is reported ahead of misalignment.
          if (!legal) begin
            err_code <= E_OPC;
            done     <= 1'b1;
            err      <= 1'b1;
            state    <= S_ERR;
          end else if (misal) begin
            err_code <= E_ALIGN;
            done     <= 1'b1;
            err      <= 1'b1;
            state    <= S_ERR;
          end else begin
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= is_sw;
            mem_addr  <= addr;
            mem_wdata <= is_sw ? req_q.wdata : '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack is checked first so a late ack beats the timeout.
          if (mem_ack) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= E_TMO;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= S_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_transfer_seq.sv
// tb_data_transfer_seq: directed and random lw/sw transactions against
// a transaction-level model of the sequencer's results and timing.
module tb_data_transfer_seq;

  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    opcode = '0;
  logic [DW-1:0] rs = '0;
  logic [DW-1:0] rt = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] model_rdata = '0;

  data_transfer_seq #(
    .DATA_W (DW),
    .TIMEOUT(TO),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One transaction. ack_lat = index of the REQ cycle that gets
  // mem_ack (0 = first); negative or >= TO means never acked.
  // Cycle numbers count negedges after the accepting edge.
  task automatic run_txn(input logic [5:0]  op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] wd,
                         input int          ack_lat,
                         input logic [31:0] rd,
                         input bit          noise);
    logic [31:0] addr;
    logic [1:0]  code;
    bit          lgl;
    bit          got;
    int          exp_req;
    int          seen;
    int          cyc;
    addr = a + b;
    lgl = (op == 6'd8) || (op == 6'd9);
    if (!lgl) code = 2'b11;
    else if (addr % 4 != 0) code = 2'b01;
    else if (ack_lat < 0 || ack_lat >= TO) code = 2'b10;
    else code = 2'b00;
    if (code == 2'b11 || code == 2'b01) exp_req = 0;
    else if (code == 2'b10) exp_req = TO;
    else exp_req = ack_lat + 1;
    seen = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    opcode = op;
    rs = a;
    rt = b;
    wdata = wd;
    mem_rdata = rd;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("err_code_clear", err_code, 2'b00);
    while (!got && cyc < 60) begin
      if (done) begin
        got = 1'b1;
      end else begin
        chk("busy_in_flight", busy, 1'b1);
        if (mem_req) begin
          chk("mem_addr", mem_addr, addr);
          chk("mem_we", mem_we, op == 6'd9);
          if (op == 6'd9) chk("mem_wdata", mem_wdata, wd);
          mem_ack = (seen == ack_lat);
          seen++;
        end else begin
          chk("mem_idle_zero",
              {mem_we, mem_addr, mem_wdata}, 0);
          mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          opcode = 6'($urandom);
          rs = $urandom;
          rt = $urandom;
          wdata = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      chk("done_bound", 1'b0, 1'b1);
    end else begin
      if (code == 2'b00 && op == 6'd8) model_rdata = rd;
      chk("done_cycle", cyc, 2 + exp_req);
      chk("req_cycles", seen, exp_req);
      chk("err", err, code != 2'b00);
      chk("err_code", err_code, code);
      chk("rdata", rdata, model_rdata);
      chk("busy_done", busy, 1'b1);
      // A start in the done cycle must be dropped.
      mem_ack = 1'b0;
      start = 1'b1;
      opcode = 6'd8;
      rs = '0;
      rt = '0;
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", done, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("err_code_hold", err_code, code);
      chk("rdata_hold", rdata, model_rdata);
      @(negedge clk);
      chk("no_queued", {busy, mem_req}, 2'b00);
    end
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          r;
    repeat (2) @(negedge clk);
    chk("reset_ctl",
        {busy, done, err, err_code, mem_req, mem_we}, 0);
    chk("reset_data", {rdata, mem_addr, mem_wdata}, 0);
    rst_n = 1'b1;

    run_txn(6'd8, 32'h100, 32'h10, 32'h0, 2,
            32'hDEADBEEF, 1'b0);
    run_txn(6'd9, 32'h200, 32'hFFFFFFFC, 32'h12345678, 0,
            32'hCAFEF00D, 1'b0);
    run_txn(6'd8, 32'h101, 32'h0, 32'h0, 0,
            32'h1, 1'b0);
    run_txn(6'd5, 32'h100, 32'h0, 32'h0, 0,
            32'h2, 1'b0);
    run_txn(6'd5, 32'h101, 32'h0, 32'h0, 0,
            32'h3, 1'b0);
    run_txn(6'd8, 32'hFFFFFFFC, 32'h8, 32'h0, 0,
            32'h11223344, 1'b0);
    run_txn(6'd8, 32'h300, 32'h0, 32'h0, -1,
            32'h4, 1'b0);
    run_txn(6'd8, 32'h300, 32'h0, 32'h0, TO - 1,
            32'h55AA55AA, 1'b0);
    run_txn(6'd9, 32'h400, 32'h4, 32'hA5A5A5A5, -1,
            32'h5, 1'b1);

    // mem_ack with no request outstanding.
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack", {busy, done, mem_req}, 3'b000);
    mem_ack = 1'b0;

    // Reset in the middle of a request.
    start = 1'b1;
    opcode = 6'd8;
    rs = 32'h500;
    rt = 32'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("req_before_rst", mem_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ctl",
        {busy, done, err, err_code, mem_req, mem_we}, 0);
    chk("rst_data", {rdata, mem_addr, mem_wdata}, 0);
    model_rdata = '0;
    rst_n = 1'b1;
    repeat (TO + 3) begin
      @(negedge clk);
      chk("no_done_after_rst", {done, busy}, 2'b00);
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = 6'd8;
      else if (r < 8) op = 6'd9;
      else op = 6'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[1:0] = 2'b00;
        b[1:0] = 2'b00;
      end
      if ($urandom_range(0, 4) == 0) lat = -1;
      else if ($urandom_range(0, 1) == 0)
        lat = $urandom_range(0, 3);
      else lat = $urandom_range(0, TO - 1);
      run_txn(op, a, b, $urandom, lat, $urandom, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
